result_bus_arbiter: RTL and testbench
=====================================

Name: result_bus_arbiter

Overview:
- Sits directly upstream of the reservation-station operand-capture logic and drives the result buses it snoops: `bus_asserted`, `bus_source` and `bus_value`.
- Each reservation station / functional unit hands its finished result in over a valid/ready handshake.
- The block buffers one result per station and grants up to BUS_COUNT buses per cycle in round-robin order.
- It broadcasts each granted result tagged with its station index.

Parameters:
- SIZE, 32, result width in bits.
- STATION_INDEX_SIZE, 1, width of the station tag; STATION_COUNT must be <= 2**STATION_INDEX_SIZE.
- STATION_COUNT, 2, number of producing stations.
- BUS_COUNT, 1, number of result buses; must satisfy 1 <= BUS_COUNT <= STATION_COUNT.

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous discard of all buffered results.
- `result_valid` input [0:STATION_COUNT-1] x 1: station i offers a result.
- `result_value` input [0:STATION_COUNT-1] x SIZE: result data from station i.
- `result_ready` output [0:STATION_COUNT-1] x 1: the arbiter accepts station i's result this cycle.
- `bus_asserted` output [0:BUS_COUNT-1] x 1: bus k carries a valid result.
- `bus_source` output [0:BUS_COUNT-1] x STATION_INDEX_SIZE: station tag on bus k.
- `bus_value` output [0:BUS_COUNT-1] x SIZE: result value on bus k.

Behaviour:
- **State.** Per station: `pending[i]` flag and `held_value[i]` register. One round-robin pointer `rr_pointer` (STATION_INDEX_SIZE bits, range 0..STATION_COUNT-1).
- **Reset.** While `reset` is low, asynchronously: `pending` = 0, `held_value` = 0, `rr_pointer` = 0. Consequently all `bus_asserted` = 0, `bus_source` = 0, `bus_value` = 0, and `result_ready[i]` = 1 unless `flush` is high.
- **Grant (combinational from registered state only).**
  - Scan stations in order `rr_pointer`, `rr_pointer`+1, ... wrapping modulo STATION_COUNT.
  - The first BUS_COUNT stations with `pending` set are granted.
  - The n-th granted station drives bus slot n with `bus_asserted`=1, `bus_source`=i, `bus_value`=`held_value[i]`.
  - Unused slots drive asserted 0, source 0, value 0.
- **Combinational paths.** No combinational path from `result_valid` or `result_value` to any bus output.
- **Ready.** `result_ready[i]` = !`flush` && (!`pending[i]` || `granted[i]`). Single-entry buffer with same-cycle drain-and-refill.
- **Accept.** On a rising edge with `result_valid[i]` && `result_ready[i]`: `pending[i]` <= 1 and `held_value[i]` <= `result_value[i]`.
- **Drain.** On a rising edge with `granted[i]` and no accept: `pending[i]` <= 0.
  - Grant plus accept in the same cycle: `pending[i]` stays 1 and `held_value[i]` takes the new value.
- **Latency.** A result accepted at edge E appears on a bus in the cycle after E at the earliest. Throughput is one result per station per cycle when that station is granted every cycle.
- **Pointer update.** If at least one grant occurs, `rr_pointer` <= (index of the last granted station + 1) mod STATION_COUNT. With no grants, it holds. Wrap from STATION_COUNT-1 goes to 0.
- **Flush.**
  - When `flush` is high: `bus_asserted` is all 0 and `result_ready` is all 0 that cycle.
  - At the edge: `pending` <= 0 and `rr_pointer` <= 0; `held_value` is unchanged.
  - `flush` overrides any accept or grant.
- **Fairness.** A pending station is granted within ceil(STATION_COUNT/BUS_COUNT) cycles of becoming pending, absent flush.
- **Elaboration checks.** Elaboration-time assertions enforce the parameter constraints.
- **Simulation assertions.** No two bus slots carry the same source in one cycle. `bus_asserted` slots are packed from slot 0 upward.

Decomposition:
- Shared package: SIZE and STATION_INDEX_SIZE defaults, and a station-tag typedef. These are shared with the operand-capture stations so bus tag widths match by construction.
- One natural sub-module: `round_robin_selector`.
  - Purely combinational.
  - Inputs: `pending` vector and `rr_pointer`.
  - Outputs: the `granted` vector, the per-slot granted index plus valid, and the next pointer.
  - Instantiated once.

Test Plan:
- **Reset.** Assert `reset`=0 mid-cycle with results pending -> `bus_asserted`=0 immediately, `rr_pointer`=0. After release, `result_ready`=1 for all stations.
- **Basic latency.** STATION_COUNT=2, BUS_COUNT=1. Station 1 offers 0xDEADBEEF at edge 1 -> bus 0 shows asserted=1, source=1, value 0xDEADBEEF in cycle 2. `pending` clears at edge 2.
- **Contention.** Both stations pending, `rr_pointer`=0 -> station 0 is granted in cycle 1 and station 1 in cycle 2, with pointer values 1 then 0.
  - Meanwhile station 0's second result, offered in cycle 1, is accepted via drain-and-refill and granted in cycle 3.
- **Back-pressure.** Station 0 pending and not granted, offering 0x5 -> `result_ready[0]`=0. The held value stays at the old value until the grant cycle.
- **Multi-bus.** STATION_COUNT=4, BUS_COUNT=2, stations 1, 2, 3 pending, `rr_pointer`=2 -> bus 0 = source 2, bus 1 = source 3, next pointer = 0. The following cycle bus 0 = source 1 and bus 1 is deasserted.
- **Flush.** Flush with stations 0 and 1 pending and valid inputs -> bus deasserted and `result_ready` = 0 that cycle. `pending` is all 0 and `rr_pointer`=0 after the edge; no stale result is ever broadcast.

Source files
------------

// File: rtl/result_bus_arbiter_pkg.sv
// result_bus_arbiter_pkg: widths and tag type shared with the operand-capture stations
package result_bus_arbiter_pkg;
  localparam int SIZE_DEFAULT = 32;
  localparam int STATION_INDEX_SIZE_DEFAULT = 1;
  typedef logic [STATION_INDEX_SIZE_DEFAULT-1:0] station_tag_t;
  function automatic int wrap_next(input int index, input int count);
    return (index + 1 >= count) ? 0 : index + 1;
  endfunction
endpackage

// File: rtl/result_bus_arbiter_round_robin_selector.sv
// round_robin_selector: picks the first BUS_COUNT pending stations starting at rr_pointer
module round_robin_selector
  import result_bus_arbiter_pkg::*;
#(
  parameter int STATION_COUNT = 2,
  parameter int BUS_COUNT = 1,
  parameter int STATION_INDEX_SIZE = 1
) (
  input  logic [0:STATION_COUNT-1] pending,
  input  logic [STATION_INDEX_SIZE-1:0] rr_pointer,
  output logic [0:STATION_COUNT-1] granted,
  output logic slot_valid [0:BUS_COUNT-1],
  output logic [STATION_INDEX_SIZE-1:0] slot_index [0:BUS_COUNT-1],
  output logic [STATION_INDEX_SIZE-1:0] next_pointer
);
  // One constant scan order per pointer value keeps every index static after unrolling
  always_comb begin
    int used;
    used = 0;
    granted = '0;
    next_pointer = rr_pointer;
    for (int b = 0; b < BUS_COUNT; b++) begin
      slot_valid[b] = 1'b0;
      slot_index[b] = '0;
    end
    for (int p = 0; p < STATION_COUNT; p++)
      if (int'(rr_pointer) == p)
        for (int o = 0; o < STATION_COUNT; o++)
          if (pending[(p + o) % STATION_COUNT] && used < BUS_COUNT) begin
            granted[(p + o) % STATION_COUNT] = 1'b1;
            for (int b = 0; b < BUS_COUNT; b++)
              if (b == used) begin
                slot_valid[b] = 1'b1;
                slot_index[b] = STATION_INDEX_SIZE'((p + o) % STATION_COUNT);
              end
            next_pointer = STATION_INDEX_SIZE'(wrap_next((p + o) % STATION_COUNT, STATION_COUNT));
            used++;
          end
  end
endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: buffers one result per station and broadcasts them round-robin
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT,
  parameter int STATION_INDEX_SIZE = STATION_INDEX_SIZE_DEFAULT,
  parameter int STATION_COUNT = 2,
  parameter int BUS_COUNT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic [0:STATION_COUNT-1] result_valid,
  input  logic [SIZE-1:0] result_value [0:STATION_COUNT-1],
  output logic [0:STATION_COUNT-1] result_ready,
  output logic [0:BUS_COUNT-1] bus_asserted,
  output logic [STATION_INDEX_SIZE-1:0] bus_source [0:BUS_COUNT-1],
  output logic [SIZE-1:0] bus_value [0:BUS_COUNT-1]
);
  if (STATION_COUNT > 2 ** STATION_INDEX_SIZE || BUS_COUNT < 1 || BUS_COUNT > STATION_COUNT) begin : g_bad_params
    $error("result_bus_arbiter: illegal STATION_COUNT/BUS_COUNT/STATION_INDEX_SIZE combination");
  end
  logic [0:STATION_COUNT-1] pending, granted;
  logic [SIZE-1:0] held_value [0:STATION_COUNT-1];
  logic [STATION_INDEX_SIZE-1:0] rr_pointer, next_pointer;
  logic slot_valid [0:BUS_COUNT-1];
  logic [STATION_INDEX_SIZE-1:0] slot_index [0:BUS_COUNT-1];
  round_robin_selector #(
    .STATION_COUNT(STATION_COUNT),
    .BUS_COUNT(BUS_COUNT),
    .STATION_INDEX_SIZE(STATION_INDEX_SIZE)
  ) selector (
    .pending(pending),
    .rr_pointer(rr_pointer),
    .granted(granted),
    .slot_valid(slot_valid),
    .slot_index(slot_index),
    .next_pointer(next_pointer)
  );
  // A granted station may refill in the same cycle it drains
  assign result_ready = {STATION_COUNT{!flush}} & (~pending | granted);
  always_comb
    for (int k = 0; k < BUS_COUNT; k++) begin
      bus_asserted[k] = slot_valid[k] && !flush;
      bus_source[k] = bus_asserted[k] ? slot_index[k] : '0;
      bus_value[k] = bus_asserted[k] ? held_value[slot_index[k]] : '0;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pending <= '0;
      rr_pointer <= '0;
      for (int i = 0; i < STATION_COUNT; i++) held_value[i] <= '0;
    end else if (flush) begin
      pending <= '0;
      rr_pointer <= '0;
    end else begin
      pending <= (pending & ~granted) | (result_valid & result_ready);
      rr_pointer <= next_pointer;
      for (int i = 0; i < STATION_COUNT; i++)
        if (result_valid[i] && result_ready[i]) held_value[i] <= result_value[i];
    end
  always_ff @(posedge clock)
    if (reset)
      for (int k = 1; k < BUS_COUNT; k++) begin
        assert (bus_asserted[k-1] || !bus_asserted[k]);
        for (int j = 0; j < k; j++)
          assert (!(bus_asserted[j] && bus_asserted[k] && bus_source[j] == bus_source[k]));
      end
endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter: scoreboard bench for a 2-station/1-bus and a 4-station/2-bus arbiter
module tb_result_bus_arbiter;
  typedef struct packed {logic [1:0] src; logic [31:0] val;} exp_t;
  logic clock = 1'b0, reset = 1'b0, flush2 = 1'b0, flush4 = 1'b0;
  logic [0:1] v2 = '0, rdy2;
  logic [31:0] val2 [0:1];
  logic [0:0] ba2;
  logic [0:0] bs2 [0:0];
  logic [31:0] bv2 [0:0];
  logic [0:3] v4 = '0, rdy4;
  logic [31:0] val4 [0:3];
  logic [0:1] ba4;
  logic [1:0] bs4 [0:1];
  logic [31:0] bv4 [0:1];
  exp_t q2[$], q4[$], e2, e4;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  result_bus_arbiter #(.SIZE(32), .STATION_INDEX_SIZE(1), .STATION_COUNT(2), .BUS_COUNT(1)) dut2 (
    .clock(clock), .reset(reset), .flush(flush2), .result_valid(v2), .result_value(val2),
    .result_ready(rdy2), .bus_asserted(ba2), .bus_source(bs2), .bus_value(bv2));
  result_bus_arbiter #(.SIZE(32), .STATION_INDEX_SIZE(2), .STATION_COUNT(4), .BUS_COUNT(2)) dut4 (
    .clock(clock), .reset(reset), .flush(flush4), .result_valid(v4), .result_value(val4),
    .result_ready(rdy4), .bus_asserted(ba4), .bus_source(bs4), .bus_value(bv4));

  // Scoreboard: every broadcast must match the next expected result, in order
  always @(negedge clock) begin
    if (ba2[0]) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL sb2_unexpected got src=%0d val=%h, expected no broadcast", bs2[0], bv2[0]);
      end else begin
        e2 = q2.pop_front();
        if ({1'b0, bs2[0]} !== e2.src || bv2[0] !== e2.val) begin
          failures++;
          $display("FAIL sb2_order got src=%0d val=%h, expected src=%0d val=%h", bs2[0], bv2[0], e2.src, e2.val);
        end
      end
    end
    for (int k = 0; k < 2; k++)
      if (ba4[k]) begin
        checks++;
        if (q4.size() == 0) begin
          failures++;
          $display("FAIL sb4_unexpected slot=%0d got src=%0d val=%h, expected no broadcast", k, bs4[k], bv4[k]);
        end else begin
          e4 = q4.pop_front();
          if (bs4[k] !== e4.src || bv4[k] !== e4.val) begin
            failures++;
            $display("FAIL sb4_order slot=%0d got src=%0d val=%h, expected src=%0d val=%h", k, bs4[k], bv4[k], e4.src, e4.val);
          end
        end
      end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ba2 !== 1'b0 || ba4 !== 2'b00) begin failures++; $display("FAIL reset_bus got %b/%b, expected 0/00", ba2, ba4); end
    checks++; if (rdy2 !== 2'b11 || rdy4 !== 4'b1111) begin failures++; $display("FAIL reset_ready got %b/%b, expected 11/1111", rdy2, rdy4); end
    @(posedge clock); step(); reset = 1'b1;
    step(); v2 = 2'b11; val2[0] = 32'h1111_0000; val2[1] = 32'h1111_0001;
    q2.push_back({2'd0, 32'h1111_0000}); q2.push_back({2'd1, 32'h1111_0001});
    step(); v2 = 2'b00; #1;
    checks++; if (ba2 !== 1'b1 || bs2[0] !== 1'b0) begin failures++; $display("FAIL reset_pre_bus got %b src=%0d, expected 1 src=0", ba2, bs2[0]); end
    step(); #5; reset = 1'b0; #1;
    checks++; if (ba2 !== 1'b0 || bv2[0] !== 32'h0) begin failures++; $display("FAIL reset_async_bus got %b val=%h, expected 0 val=0", ba2, bv2[0]); end
    step(); reset = 1'b1; #1;
    checks++; if (ba2 !== 1'b0 || rdy2 !== 2'b11) begin failures++; $display("FAIL reset_release got bus=%b ready=%b, expected 0/11", ba2, rdy2); end
  endtask

  task automatic test_basic_latency();
    step(); v2 = 2'b01; val2[1] = 32'hDEADBEEF; q2.push_back({2'd1, 32'hDEADBEEF}); #1;
    checks++; if (ba2 !== 1'b0 || rdy2[1] !== 1'b1) begin failures++; $display("FAIL latency_early got bus=%b ready=%b, expected 0/1", ba2, rdy2[1]); end
    step(); v2 = 2'b00; #1;
    checks++; if (ba2 !== 1'b1 || bs2[0] !== 1'b1 || bv2[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL latency_bus got %b src=%0d val=%h, expected 1 src=1 val=deadbeef", ba2, bs2[0], bv2[0]); end
    step(); #1;
    checks++; if (ba2 !== 1'b0) begin failures++; $display("FAIL latency_drain got %b, expected 0", ba2); end
  endtask

  task automatic test_contention();
    q2.push_back({2'd0, 32'hA0}); q2.push_back({2'd1, 32'hA1}); q2.push_back({2'd0, 32'hB0});
    step(); v2 = 2'b11; val2[0] = 32'hA0; val2[1] = 32'hA1;
    step(); v2 = 2'b10; val2[0] = 32'hB0; #1;
    checks++; if (bs2[0] !== 1'b0 || rdy2 !== 2'b10) begin failures++; $display("FAIL contention_c1 got src=%0d ready=%b, expected src=0 ready=10", bs2[0], rdy2); end
    step(); v2 = 2'b00; #1;
    checks++; if (ba2 !== 1'b1 || bs2[0] !== 1'b1) begin failures++; $display("FAIL contention_c2 got %b src=%0d, expected 1 src=1", ba2, bs2[0]); end
    step(); #1;
    checks++; if (ba2 !== 1'b1 || bs2[0] !== 1'b0 || bv2[0] !== 32'hB0) begin failures++; $display("FAIL contention_c3 got %b src=%0d val=%h, expected 1 src=0 val=b0", ba2, bs2[0], bv2[0]); end
    step(); #1;
    checks++; if (ba2 !== 1'b0) begin failures++; $display("FAIL contention_idle got %b, expected 0", ba2); end
  endtask

  task automatic test_back_pressure();
    q2.push_back({2'd1, 32'hC1}); q2.push_back({2'd0, 32'hC0}); q2.push_back({2'd0, 32'h5});
    step(); v2 = 2'b11; val2[0] = 32'hC0; val2[1] = 32'hC1;
    step(); v2 = 2'b10; val2[0] = 32'h5; #1;
    checks++; if (rdy2 !== 2'b01 || bs2[0] !== 1'b1) begin failures++; $display("FAIL backpressure_ready got ready=%b src=%0d, expected ready=01 src=1", rdy2, bs2[0]); end
    step(); #1;
    checks++; if (bs2[0] !== 1'b0 || bv2[0] !== 32'hC0 || rdy2[0] !== 1'b1) begin failures++; $display("FAIL backpressure_held got src=%0d val=%h ready=%b, expected src=0 val=c0 ready=1", bs2[0], bv2[0], rdy2[0]); end
    step(); v2 = 2'b00; #1;
    checks++; if (bv2[0] !== 32'h5) begin failures++; $display("FAIL backpressure_refill got val=%h, expected 5", bv2[0]); end
    step();
  endtask

  task automatic test_flush();
    step(); v2 = 2'b11; val2[0] = 32'hD0; val2[1] = 32'hD1;
    step(); flush2 = 1'b1; val2[0] = 32'hE0; val2[1] = 32'hE1; #1;
    checks++; if (ba2 !== 1'b0 || rdy2 !== 2'b00) begin failures++; $display("FAIL flush_cycle got bus=%b ready=%b, expected 0/00", ba2, rdy2); end
    step(); flush2 = 1'b0; v2 = 2'b00; #1;
    checks++; if (ba2 !== 1'b0 || rdy2 !== 2'b11) begin failures++; $display("FAIL flush_after got bus=%b ready=%b, expected 0/11", ba2, rdy2); end
    q2.push_back({2'd0, 32'hF0}); q2.push_back({2'd1, 32'hF1});
    step(); v2 = 2'b11; val2[0] = 32'hF0; val2[1] = 32'hF1;
    step(); v2 = 2'b00; #1;
    checks++; if (bs2[0] !== 1'b0 || bv2[0] !== 32'hF0) begin failures++; $display("FAIL flush_pointer got src=%0d val=%h, expected src=0 val=f0", bs2[0], bv2[0]); end
    step(); step();
  endtask

  task automatic test_multi_bus();
    step(); v4 = 4'b0100; val4[1] = 32'h41; q4.push_back({2'd1, 32'h41});
    q4.push_back({2'd2, 32'h52}); q4.push_back({2'd3, 32'h53}); q4.push_back({2'd1, 32'h51});
    step(); v4 = 4'b0111; val4[1] = 32'h51; val4[2] = 32'h52; val4[3] = 32'h53; #1;
    checks++; if (ba4 !== 2'b10 || bs4[0] !== 2'd1 || rdy4 !== 4'b1111) begin failures++; $display("FAIL multi_setup got bus=%b src=%0d ready=%b, expected 10 src=1 ready=1111", ba4, bs4[0], rdy4); end
    step(); v4 = 4'b0000; #1;
    checks++; if (ba4 !== 2'b11 || bs4[0] !== 2'd2 || bs4[1] !== 2'd3) begin failures++; $display("FAIL multi_two got bus=%b src=%0d/%0d, expected 11 src=2/3", ba4, bs4[0], bs4[1]); end
    step(); #1;
    checks++; if (ba4 !== 2'b10 || bs4[0] !== 2'd1 || bs4[1] !== 2'd0 || bv4[1] !== 32'h0) begin failures++; $display("FAIL multi_wrap got bus=%b src=%0d/%0d val1=%h, expected 10 src=1/0 val1=0", ba4, bs4[0], bs4[1], bv4[1]); end
    step(); #1;
    checks++; if (ba4 !== 2'b00) begin failures++; $display("FAIL multi_idle got %b, expected 00", ba4); end
  endtask

  initial begin
    val2[0] = '0; val2[1] = '0;
    for (int i = 0; i < 4; i++) val4[i] = '0;
    test_reset();
    test_basic_latency();
    test_contention();
    test_back_pressure();
    test_flush();
    test_multi_bus();
    step(); step();
    checks++; if (q2.size() != 0) begin failures++; $display("FAIL sb2_drained got %0d left, expected 0", q2.size()); end
    checks++; if (q4.size() != 0) begin failures++; $display("FAIL sb4_drained got %0d left, expected 0", q4.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
